// File: rtl/digital_pattern_generator_pkg.sv
// Shared command codes, upload constants and FSM state type
// for the 8-channel digital pattern generator.
package digital_pattern_generator_pkg;

    localparam logic [7:0] CMD_DP_LOAD      = 8'h0D;
    localparam logic [7:0] CMD_DP_START     = 8'h0E;
    localparam logic [7:0] CMD_DP_STOP      = 8'h0F;
    localparam logic [7:0] UPLOAD_SOURCE_DP = 8'h0D;
    localparam logic [7:0] DP_STATUS_DONE   = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT
    } dp_state_t;

    // A divider of zero behaves like one.
    function automatic logic [15:0] div_limit(input logic [15:0] d);
        return (d == 16'd0) ? 16'd0 : d - 16'd1;
    endfunction

endpackage

// File: rtl/dp_pattern_ram.sv
// Pattern buffer: one write port, one read port with a
// registered (1-cycle) read.
module dp_pattern_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/digital_pattern_generator.sv
// Loads a pattern over the command bus and replays it on
// 8 pins at clk/div, one-shot (with done report) or looped.
module digital_pattern_generator
    import digital_pattern_generator_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [15:0] DIV_DEFAULT = 16'd60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_type,
    input  logic [15:0] cmd_length,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_data_index,
    input  logic        cmd_start,
    input  logic        cmd_data_valid,
    input  logic        cmd_done,
    output logic        cmd_ready,
    output logic [7:0]  dp_signal_out,
    output logic        dp_busy,
    output logic        upload_active,
    output logic        upload_req,
    output logic [7:0]  upload_data,
    output logic [7:0]  upload_source,
    output logic        upload_valid,
    input  logic        upload_ready
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    dp_state_t     state, state_nxt;
    logic [15:0]   div, cnt, len_q, pay, wr_off;
    logic          loop;
    logic [AW:0]   pattern_len, len_calc;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    rd_data;
    logic          is_load, is_start, is_stop;
    logic          wr_en, fetch, is_last;
    logic          load_q, last_q, fetched_last, emit_last;

    assign is_load  = cmd_start && (cmd_type == CMD_DP_LOAD);
    assign is_start = cmd_start && (cmd_type == CMD_DP_START);
    assign is_stop  = cmd_start && (cmd_type == CMD_DP_STOP);

    assign wr_off = cmd_data_index - 16'd3;
    assign wr_en  = (state == S_LOAD) && cmd_data_valid
                 && (cmd_data_index >= 16'd3) && (wr_off[15:AW] == '0);

    assign pay      = len_q - 16'd3;
    assign len_calc = (len_q <= 16'd3)  ? '0 :
                      (pay >= DEPTH16)  ? DEPTH_W : pay[AW:0];

    // A fetch reads the RAM; the byte reaches the pins one cycle later.
    assign is_last   = ({1'b0, rd_ptr} == pattern_len - (AW+1)'(1));
    assign fetch     = (state == S_RUN) && (cnt == 16'd0) && !fetched_last;
    assign emit_last = load_q && last_q && !loop;

    dp_pattern_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_off[AW-1:0]),
        .wr_data (cmd_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (is_load)
                    state_nxt = S_LOAD;
                else if (is_start && (pattern_len != '0))
                    state_nxt = S_RUN;
            end
            S_LOAD: begin
                if (cmd_done)
                    state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (is_stop)
                    state_nxt = S_IDLE;
                else if (emit_last)
                    state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (upload_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state != S_REPORT);
        dp_busy       = (state == S_RUN);
        upload_active = (state == S_REPORT);
        upload_req    = (state == S_REPORT);
        upload_valid  = (state == S_REPORT) && upload_ready;
        upload_data   = (state == S_REPORT) ? DP_STATUS_DONE : 8'h00;
        upload_source = UPLOAD_SOURCE_DP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div           <= DIV_DEFAULT;
            loop          <= 1'b0;
            len_q         <= 16'd0;
            pattern_len   <= '0;
            rd_ptr        <= '0;
            cnt           <= 16'd0;
            load_q        <= 1'b0;
            last_q        <= 1'b0;
            fetched_last  <= 1'b0;
            dp_signal_out <= 8'h00;
        end else begin
            if (state == S_IDLE && is_load)
                len_q <= cmd_length;
            if (state == S_LOAD && cmd_data_valid) begin
                if (cmd_data_index == 16'd0)
                    div[15:8] <= cmd_data;
                else if (cmd_data_index == 16'd1)
                    div[7:0] <= cmd_data;
                else if (cmd_data_index == 16'd2)
                    loop <= cmd_data[0];
            end
            if (state == S_LOAD && cmd_done)
                pattern_len <= len_calc;

            if (state != S_RUN)
                cnt <= 16'd0;
            else if (cnt >= div_limit(div))
                cnt <= 16'd0;
            else
                cnt <= cnt + 16'd1;

            if (state != S_RUN)
                rd_ptr <= '0;
            else if (fetch)
                rd_ptr <= is_last ? '0 : rd_ptr + AW'(1);

            if (state != S_RUN)
                fetched_last <= 1'b0;
            else if (fetch && is_last && !loop)
                fetched_last <= 1'b1;

            load_q <= fetch;
            last_q <= fetch && is_last;
            if (state == S_RUN && load_q)
                dp_signal_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_digital_pattern_generator.sv
// Scoreboard bench: expected output bytes are queued with their
// due cycle at START and compared when that cycle arrives.
module tb_digital_pattern_generator;
    import digital_pattern_generator_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_data_index;
    logic        cmd_start, cmd_data_valid, cmd_done;
    logic        cmd_ready, dp_busy, upload_active, upload_req;
    logic        upload_valid, upload_ready;
    logic [7:0]  dp_signal_out, upload_data, upload_source;

    exp_t       exp_q[$];
    logic [7:0] pat [0:299];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         upl_cnt = 0;
    int         exp_upl = 0;
    int         t;
    int         bad;

    digital_pattern_generator dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_type       (cmd_type),
        .cmd_length     (cmd_length),
        .cmd_data       (cmd_data),
        .cmd_data_index (cmd_data_index),
        .cmd_start      (cmd_start),
        .cmd_data_valid (cmd_data_valid),
        .cmd_done       (cmd_done),
        .cmd_ready      (cmd_ready),
        .dp_signal_out  (dp_signal_out),
        .dp_busy        (dp_busy),
        .upload_active  (upload_active),
        .upload_req     (upload_req),
        .upload_data    (upload_data),
        .upload_source  (upload_source),
        .upload_valid   (upload_valid),
        .upload_ready   (upload_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk($sformatf("out@%0d", e.cyc), dp_signal_out, e.val);
        end
        if (upload_valid) begin
            upl_cnt++;
            chk("upl_data", upload_data, 8'h01);
            chk("upl_src", upload_source, 8'h0D);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] ty);
        cmd_start  = 1'b1;
        cmd_type   = ty;
        cmd_length = 16'd0;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [7:0] m,
                           input int n);
        cmd_start  = 1'b1;
        cmd_type   = CMD_DP_LOAD;
        cmd_length = 16'(n + 3);
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < n + 3; i++) begin
            cmd_data_valid = 1'b1;
            cmd_data_index = 16'(i);
            if (i == 0)      cmd_data = d[15:8];
            else if (i == 1) cmd_data = d[7:0];
            else if (i == 2) cmd_data = m;
            else             cmd_data = pat[i-3];
            @(negedge clk);
        end
        cmd_data_valid = 1'b0;
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    task automatic start_run(input int d_eff, input int n, input int reps,
                             input logic busy_exp, output int ts);
        ts = cyc + 1;
        for (int k = 0; k < reps; k++)
            exp_q.push_back('{cyc: ts + 2 + k * d_eff, val: pat[k % n]});
        cmd_start = 1'b1;
        cmd_type  = CMD_DP_START;
        @(negedge clk);
        cmd_start = 1'b0;
        chk("busy_after_start", dp_busy, busy_exp);
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (exp_q.size() > 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cmd_type = 8'h00;
        cmd_length = 16'd0;
        cmd_data = 8'h00;
        cmd_data_index = 16'd0;
        cmd_start = 1'b0;
        cmd_data_valid = 1'b0;
        cmd_done = 1'b0;
        upload_ready = 1'b1;
        tick(2);
        chk("rst_out", dp_signal_out, 8'h00);
        chk("rst_busy", dp_busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_req", upload_req, 1'b0);
        chk("rst_valid", upload_valid, 1'b0);
        chk("rst_active", upload_active, 1'b0);
        chk("rst_data", upload_data, 8'h00);
        chk("rst_src", upload_source, 8'h0D);
        rst = 1'b0;
        tick(1);

        // One-shot, div 4
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hFF; pat[3] = 8'h00;
        do_load(16'd4, 8'h00, 4);
        start_run(4, 4, 4, 1'b1, t);
        drain(100);
        tick(4);
        exp_upl++;
        chk("t1_uploads", upl_cnt, exp_upl);
        chk("t1_hold", dp_signal_out, 8'h00);
        chk("t1_busy", dp_busy, 1'b0);
        chk("t1_ready", cmd_ready, 1'b1);

        // Looped, div 1, stopped mid-run
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04;
        do_load(16'd1, 8'h01, 3);
        start_run(1, 3, 11, 1'b1, t);
        wait_cyc(t + 11);
        send_cmd(CMD_DP_STOP);
        drain(50);
        tick(5);
        chk("t2_hold", dp_signal_out, 8'h02);
        chk("t2_busy", dp_busy, 1'b0);
        chk("t2_uploads", upl_cnt, exp_upl);

        // div 0 behaves as div 1
        do_load(16'd0, 8'h01, 3);
        start_run(1, 3, 7, 1'b1, t);
        wait_cyc(t + 7);
        send_cmd(CMD_DP_STOP);
        drain(50);
        tick(3);
        chk("t3_hold", dp_signal_out, 8'h01);

        // Empty pattern: START ignored
        do_load(16'd5, 8'h00, 0);
        start_run(1, 0, 0, 1'b0, t);
        tick(5);
        chk("t3_empty_busy", dp_busy, 1'b0);
        chk("t3_empty_out", dp_signal_out, 8'h01);
        chk("t3_empty_upl", upl_cnt, exp_upl);

        // Overlong load: only DEPTH bytes kept
        for (int i = 0; i < 300; i++)
            pat[i] = (i < 256) ? 8'(i * 7 + 3) : 8'hEE;
        do_load(16'd1, 8'h00, 263);
        start_run(1, 256, 256, 1'b1, t);
        drain(400);
        tick(4);
        exp_upl++;
        chk("t4_uploads", upl_cnt, exp_upl);
        chk("t4_last", dp_signal_out, pat[255]);

        // Completion with the arbiter stalled
        upload_ready = 1'b0;
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hFF; pat[3] = 8'h00;
        do_load(16'd2, 8'h00, 4);
        start_run(2, 4, 4, 1'b1, t);
        drain(100);
        tick(1);
        chk("t5_req", upload_req, 1'b1);
        chk("t5_cmd_ready", cmd_ready, 1'b0);
        chk("t5_active", upload_active, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) send_cmd(CMD_DP_START);
            else         @(negedge clk);
            if (!upload_req || cmd_ready || upload_valid) bad++;
        end
        chk("t5_stall", bad, 0);
        @(posedge clk);
        #1 upload_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid", upload_valid, 1'b1);
        @(negedge clk);
        chk("t5_valid_off", upload_valid, 1'b0);
        chk("t5_req_off", upload_req, 1'b0);
        chk("t5_idle", cmd_ready, 1'b1);
        chk("t5_no_run", dp_busy, 1'b0);
        exp_upl++;
        chk("t5_uploads", upl_cnt, exp_upl);

        // Reset during RUN
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04;
        do_load(16'd1, 8'h01, 3);
        start_run(1, 3, 3, 1'b1, t);
        wait_cyc(t + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_run_out", dp_signal_out, 8'h00);
        chk("t6_run_busy", dp_busy, 1'b0);
        chk("t6_run_ready", cmd_ready, 1'b1);
        start_run(1, 0, 0, 1'b0, t);
        tick(3);
        chk("t6_run_after", dp_signal_out, 8'h00);

        // Reset during REPORT
        upload_ready = 1'b0;
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hFF; pat[3] = 8'h00;
        do_load(16'd1, 8'h00, 4);
        start_run(1, 4, 4, 1'b1, t);
        drain(50);
        tick(1);
        chk("t6_rep_req", upload_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rep_req_off", upload_req, 1'b0);
        chk("t6_rep_active", upload_active, 1'b0);
        chk("t6_rep_data", upload_data, 8'h00);
        chk("t6_rep_out", dp_signal_out, 8'h00);
        chk("t6_rep_ready", cmd_ready, 1'b1);
        upload_ready = 1'b1;
        start_run(1, 0, 0, 1'b0, t);
        tick(3);
        chk("t6_rep_uploads", upl_cnt, exp_upl);
        chk("t6_rep_src", upload_source, 8'h0D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
